// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, FSM states and the 3-to-8 decode function
package decoder_pkg;
    localparam int CODE_W = 3;
    localparam int OUT_W = 8;
    typedef enum logic {IDLE, DRIVE} state_t;
    function automatic logic [OUT_W-1:0] onehot3(input logic en, input logic [CODE_W-1:0] code);
        return en ? OUT_W'(1) << code : '0;
    endfunction
endpackage

// File: rtl/decoder_three_8_seq_if.sv
// decoder_three_8_seq_if: entry handshake plus decoded output bundle
interface decoder_three_8_seq_if #(parameter int DEPTH = 4);
    logic in_valid;
    logic in_ready;
    logic [2:0] in_code;
    logic in_en;
    logic [7:0] op;
    logic op_valid;
    logic busy;
    logic [$clog2(DEPTH):0] level;
    modport master (output in_valid, in_code, in_en, input in_ready, op, op_valid, busy, level);
    modport slave (input in_valid, in_code, in_en, output in_ready, op, op_valid, busy, level);
endinterface

// File: rtl/decoder_three_8_seq_sync_fifo.sv
// sync_fifo: power-of-2 FIFO with registered occupancy and combinational head read
module sync_fifo #(
    parameter int W = 4,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    assign full = level == LW'(DEPTH);
    assign empty = level == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp <= wp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end
endmodule

// File: rtl/decoder_three_8_seq.sv
// decoder_three_8_seq: queued 3-to-8 decoder holding each one-hot output for HOLD cycles
module decoder_three_8_seq import decoder_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int HOLD = 3
) (
    input logic clk,
    input logic rst,
    decoder_three_8_seq_if.slave bus
);
    localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [OUT_W-1:0] op, op_n;
    logic op_valid, op_valid_n;
    logic push, pop, full, empty;
    logic [CODE_W:0] dout;
    assign bus.in_ready = !rst && !full;
    assign push = bus.in_valid && bus.in_ready;
    assign bus.op = op;
    assign bus.op_valid = op_valid;
    assign bus.busy = state == DRIVE || !empty;
    sync_fifo #(.W(CODE_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din({bus.in_en, bus.in_code}),
        .dout(dout),
        .full(full),
        .empty(empty),
        .level(bus.level)
    );
    // a zero count in DRIVE means the current slot ends this cycle, so the next entry loads with no gap
    always_comb begin
        pop = !empty && (state == IDLE || cnt == '0);
        state_n = (pop || (state == DRIVE && cnt != '0)) ? DRIVE : IDLE;
        cnt_n = pop ? CW'(HOLD - 1) : (cnt != '0 ? cnt - CW'(1) : cnt);
        op_n = pop ? onehot3(dout[CODE_W], dout[CODE_W-1:0]) : (state_n == DRIVE ? op : '0);
        op_valid_n = state_n == DRIVE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            op <= '0;
            op_valid <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            op <= op_n;
            op_valid <= op_valid_n;
        end
    end
endmodule

// File: tb/tb_decoder_three_8_seq.sv
// tb_decoder_three_8_seq: directed checks of decode, hold timing, backpressure and reset flush
module tb_decoder_three_8_seq;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int fails = 0;
    decoder_three_8_seq_if #(.DEPTH(4)) a ();
    decoder_three_8_seq_if #(.DEPTH(4)) b ();
    decoder_three_8_seq #(.DEPTH(4), .HOLD(3)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    decoder_three_8_seq #(.DEPTH(4), .HOLD(1)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
    always #5 clk = ~clk;

    int pushed, first, last, caps, nv, nok;
    bit saw_full;
    logic [7:0] seen [$];
    logic [7:0] e;
    logic [2:0] lvl_exp [12] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3, 3'd4, 3'd4, 3'd3};
    logic [2:0] codes6 [6] = '{3'd7, 3'd0, 3'd3, 3'd5, 3'd2, 3'd6};
    logic [7:0] ops6 [6] = '{8'h80, 8'h01, 8'h08, 8'h20, 8'h04, 8'h40};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a.in_valid = 1'b0; a.in_en = 1'b0; a.in_code = 3'd0;
        b.in_valid = 1'b0; b.in_en = 1'b0; b.in_code = 3'd0;
        step;
        step;
        chk("rst_op", a.op, 8'h00);
        chk("rst_op_valid", a.op_valid, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_level", a.level, 0);
        chk("rst_in_ready", a.in_ready, 0);
        chk("rst_b_op_valid", b.op_valid, 0);
        rst = 1'b0;
        step;
        chk("post_rst_in_ready", a.in_ready, 1);

        // single entry, code 5
        a.in_valid = 1'b1; a.in_en = 1'b1; a.in_code = 3'd5;
        step;
        a.in_valid = 1'b0;
        chk("t1_c1_op_valid", a.op_valid, 0);
        chk("t1_c1_busy", a.busy, 1);
        chk("t1_c1_level", a.level, 1);
        step;
        for (int k = 0; k < 3; k++) begin
            chk("t1_hold_op", a.op, 8'h20);
            chk("t1_hold_op_valid", a.op_valid, 1);
            step;
        end
        chk("t1_end_op", a.op, 8'h00);
        chk("t1_end_op_valid", a.op_valid, 0);
        chk("t1_end_busy", a.busy, 0);

        // codes 0..7 back-to-back with backpressure
        pushed = 0; first = -1; last = -1; saw_full = 1'b0;
        seen.delete();
        for (int cyc = 0; cyc < 60; cyc++) begin
            a.in_valid = pushed < 8; a.in_en = 1'b1; a.in_code = 3'(pushed);
            if (!a.in_ready) saw_full = 1'b1;
            if (a.in_valid && a.in_ready) pushed++;
            step;
            chk("t2_level_max", a.level <= 3'd4, 1);
            chk("t2_ready_vs_level", a.in_ready, a.level != 3'd4);
            if (a.op_valid) begin
                seen.push_back(a.op);
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        a.in_valid = 1'b0;
        chk("t2_pushed", pushed, 8);
        chk("t2_saw_full", saw_full, 1);
        chk("t2_out_count", seen.size(), 24);
        chk("t2_contiguous", last - first + 1, 24);
        for (int k = 0; k < 24 && k < seen.size(); k++) begin
            e = 8'h01 << (k / 3);
            chk("t2_walk_op", seen[k], e);
        end

        // disabled entry
        a.in_valid = 1'b1; a.in_en = 1'b0; a.in_code = 3'd6;
        step;
        a.in_valid = 1'b0;
        step;
        for (int k = 0; k < 3; k++) begin
            chk("t3_op_zero", a.op, 8'h00);
            chk("t3_op_valid", a.op_valid, 1);
            step;
        end
        chk("t3_end_op_valid", a.op_valid, 0);

        // hold in_valid through a full FIFO
        a.in_valid = 1'b1; a.in_en = 1'b1; a.in_code = 3'd3;
        caps = 0; nv = 0; nok = 0;
        for (int c = 0; c < 12; c++) begin
            chk("t4_level", a.level, lvl_exp[c]);
            chk("t4_in_ready", a.in_ready, lvl_exp[c] != 3'd4);
            if (a.in_ready) caps++;
            if (a.op_valid) nv++;
            if (a.op_valid && a.op === 8'h08) nok++;
            step;
        end
        a.in_valid = 1'b0;
        chk("t4_final_level", a.level, 4);
        chk("t4_captures", caps, 8);
        for (int c = 0; c < 40; c++) begin
            if (a.op_valid) nv++;
            if (a.op_valid && a.op === 8'h08) nok++;
            step;
        end
        chk("t4_valid_cycles", nv, 24);
        chk("t4_op_cycles", nok, 24);

        // reset during DRIVE with two queued entries
        a.in_valid = 1'b1; a.in_en = 1'b1; a.in_code = 3'd1;
        step;
        a.in_code = 3'd2;
        step;
        a.in_code = 3'd4;
        step;
        a.in_valid = 1'b0;
        chk("t5_pre_level", a.level, 2);
        chk("t5_pre_op", a.op, 8'h02);
        chk("t5_pre_op_valid", a.op_valid, 1);
        rst = 1'b1;
        step;
        chk("t5_rst_op", a.op, 8'h00);
        chk("t5_rst_op_valid", a.op_valid, 0);
        chk("t5_rst_level", a.level, 0);
        chk("t5_rst_busy", a.busy, 0);
        chk("t5_rst_in_ready", a.in_ready, 0);
        rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            step;
            if (a.op_valid) nv++;
        end
        chk("t5_no_replay", nv, 0);
        chk("t5_idle_busy", a.busy, 0);

        // HOLD=1 streaming
        seen.delete();
        first = -1; last = -1;
        for (int i = 0; i < 6; i++) begin
            b.in_valid = 1'b1; b.in_en = 1'b1; b.in_code = codes6[i];
            chk("t6_in_ready", b.in_ready, 1);
            if (b.op_valid) begin
                seen.push_back(b.op);
                if (first < 0) first = i;
                last = i;
            end
            step;
        end
        b.in_valid = 1'b0;
        for (int i = 6; i < 16; i++) begin
            if (b.op_valid) begin
                seen.push_back(b.op);
                if (first < 0) first = i;
                last = i;
            end
            step;
        end
        chk("t6_out_count", seen.size(), 6);
        chk("t6_first_cycle", first, 2);
        chk("t6_contiguous", last - first + 1, 6);
        for (int k = 0; k < 6 && k < seen.size(); k++) chk("t6_op", seen[k], ops6[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
